// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative unsigned MULTU/DIVU engine that also owns the HI/LO registers
//   of the pipelined core. It runs one radix-2 step per clock, so each
//   operation takes WIDTH RUN cycles followed by a single DONE cycle.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no operation in flight; hi/lo hold the last result
//   RUN   | one multiply/divide step per clock; busy=1
//   DONE  | hi/lo were just committed; done=1; a new start is accepted
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   start          qualified mul/div issue from EX
//   mul0_div1_sel  0 = MULTU, 1 = DIVU (sampled with start)
//   op_a, op_b     multiplicand/dividend and multiplier/divisor (sampled with start)
//   hilo_rd        MFHI/MFLO in EX wants HI/LO
//   busy           high while in RUN
//   done           one-cycle pulse when hi/lo have just been updated
//   stall_req      freeze F/D and bubble E while RUN sees a read or a new op
//   hi, lo         product[2W-1:W]/remainder and product[W-1:0]/quotient
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mul0_div1_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hilo_rd,
  output logic             busy,
  output logic             done,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             last_step;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  // multiplicand for MULTU, divisor for DIVU
  logic [WIDTH-1:0] operand;
  // MULTU: {upper partial product, remaining multiplier bits}
  // DIVU:  {partial remainder, dividend/quotient shift register}
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] hi_q, lo_q;

  assign last_step = (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_step) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign stall_req = busy & (hilo_rd | start);

  // One radix-2 step. The multiply keeps the adder carry as the new top bit
  // of the shifted accumulator; the divide compares at WIDTH+1 bits so the
  // bit shifted out of the remainder is not lost. When the compare passes the
  // true difference is below the divisor, so a WIDTH-bit subtract is exact.
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, operand});
    if (is_div) begin
      step_hi = rem_ge ? (rem_sh[WIDTH-1:0] - operand) : rem_sh[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], rem_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // The working accumulators are separate from hi/lo so a new operation
  // cannot disturb the previous result before its own commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      is_div  <= 1'b0;
      operand <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (accept) begin
      cnt     <= '0;
      is_div  <= mul0_div1_sel;
      operand <= mul0_div1_sel ? op_b : op_a;
      acc_hi  <= '0;
      acc_lo  <= mul0_div1_sel ? op_a : op_b;
    end else if (busy) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      if (last_step) begin
        hi_q <= step_hi;
        lo_q <= step_lo;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         mul0_div1_sel;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         hilo_rd;
  logic         busy;
  logic         done;
  logic         stall_req;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] cur_hi, cur_lo;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mul0_div1_sel (mul0_div1_sel),
    .op_a          (op_a),
    .op_b          (op_b),
    .hilo_rd       (hilo_rd),
    .busy          (busy),
    .done          (done),
    .stall_req     (stall_req),
    .hi            (hi),
    .lo            (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit product, or quotient/remainder with the natural
  // restoring answer for a zero divisor.
  function automatic void model(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l);
    logic [63:0] p;
    if (!sel) begin
      p = {32'd0, a} * {32'd0, b};
      h = p[63:32];
      l = p[31:0];
    end else if (b == 0) begin
      h = a;
      l = '1;
    end else begin
      h = a % b;
      l = a / b;
    end
  endfunction

  // Called mid-cycle with the DUT in IDLE or DONE. Issues one op, checks every
  // RUN cycle and the DONE cycle. With chain=1, start stays high carrying the
  // next op so it gets accepted on the DONE edge.
  task automatic run_op(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic rd, input logic chain,
                        input logic nsel, input logic [W-1:0] na, input logic [W-1:0] nb);
    logic [W-1:0] eh, el;
    model(sel, a, b, eh, el);
    start = 1'b1;
    mul0_div1_sel = sel;
    op_a = a;
    op_b = b;
    hilo_rd = rd;
    @(posedge clk);
    #1;
    if (chain) begin
      mul0_div1_sel = nsel;
      op_a = na;
      op_b = nb;
    end else begin
      start = 1'b0;
      mul0_div1_sel = ~sel;
      op_a = $urandom;
      op_b = $urandom;
    end
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_hi_hold", hi, cur_hi);
      chk("run_lo_hold", lo, cur_lo);
      chk("run_stall", stall_req, rd | chain);
      @(posedge clk);
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_stall", stall_req, 0);
    chk("done_hi", hi, eh);
    chk("done_lo", lo, el);
    cur_hi = eh;
    cur_lo = el;
  endtask

  task automatic idle_check();
    start = 1'b0;
    hilo_rd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_hi", hi, cur_hi);
    chk("idle_lo", lo, cur_lo);
  endtask

  localparam int NR = 10;
  logic         r_sel [NR];
  logic [W-1:0] r_a   [NR];
  logic [W-1:0] r_b   [NR];
  logic         r_rd  [NR];
  logic         r_ch  [NR];

  initial begin
    int done_seen;
    rst = 1'b1;
    start = 1'b1;
    hilo_rd = 1'b1;
    mul0_div1_sel = 1'b0;
    op_a = '0;
    op_b = '0;
    cur_hi = '0;
    cur_lo = '0;
    #2 rst = 1'b0;
    #10;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    start = 1'b0;
    hilo_rd = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // T1
    run_op(1'b0, 32'd7, 32'd6, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("t1_lo_const", lo, 32'h0000_002A);
    chk("t1_hi_const", hi, 32'h0000_0000);
    idle_check();
    // T2
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, '0, '0);
    chk("t2_hi_const", hi, 32'hFFFF_FFFE);
    chk("t2_lo_const", lo, 32'h0000_0001);
    idle_check();
    // T3
    run_op(1'b1, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("t3_lo_const", lo, 32'h0000_000E);
    chk("t3_hi_const", hi, 32'h0000_0002);
    idle_check();
    run_op(1'b1, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("t3z_lo_const", lo, 32'hFFFF_FFFF);
    chk("t3z_hi_const", hi, 32'h0000_0005);
    idle_check();
    // T5: second op is held on start through the first one
    run_op(1'b0, 32'd3, 32'd4, 1'b0, 1'b1, 1'b1, 32'd1000, 32'd33);
    chk("t5_lo_first", lo, 32'd12);
    run_op(1'b1, 32'd1000, 32'd33, 1'b1, 1'b0, 1'b0, '0, '0);
    idle_check();
    // zero operands take full latency
    run_op(1'b0, 32'd0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, '0, '0);
    idle_check();
    run_op(1'b1, 32'd0, 32'd9, 1'b0, 1'b0, 1'b0, '0, '0);
    idle_check();

    // T6: reset in RUN cycle 10
    run_op(1'b0, 32'hDEAD_BEEF, 32'h0000_0003, 1'b0, 1'b0, 1'b0, '0, '0);
    idle_check();
    start = 1'b1;
    mul0_div1_sel = 1'b0;
    op_a = 32'd11;
    op_b = 32'd13;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    hilo_rd = 1'b1;
    start = 1'b1;
    #1;
    chk("t6_pre_stall", stall_req, 1);
    rst = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_stall", stall_req, 0);
    chk("t6_hi", hi, 0);
    chk("t6_lo", lo, 0);
    cur_hi = '0;
    cur_lo = '0;
    start = 1'b0;
    hilo_rd = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("t6_no_done", done_seen, 0);
    chk("t6_hi_after", hi, 0);
    chk("t6_lo_after", lo, 0);

    // randomized ops against the reference model
    for (int i = 0; i < NR; i++) begin
      r_sel[i] = 1'($urandom_range(0, 1));
      r_a[i]   = $urandom >> $urandom_range(0, 31);
      if (r_sel[i] && $urandom_range(0, 4) == 0) r_b[i] = '0;
      else r_b[i] = $urandom >> $urandom_range(0, 31);
      r_rd[i]  = 1'($urandom_range(0, 1));
      r_ch[i]  = (i < NR - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    for (int i = 0; i < NR; i++) begin
      if (r_ch[i])
        run_op(r_sel[i], r_a[i], r_b[i], r_rd[i], 1'b1, r_sel[i+1], r_a[i+1], r_b[i+1]);
      else begin
        run_op(r_sel[i], r_a[i], r_b[i], r_rd[i], 1'b0, 1'b0, '0, '0);
        idle_check();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
